// File: rtl/music_req_arbiter_if.sv
// Request/grant bundle between the requester side and music_req_arbiter.
// The arbiter takes the slave modport; requesters and the player-facing logic take master.
interface music_req_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned SEL_W = 4
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*SEL_W-1:0] req_sel;
    logic [SEL_W-1:0]       select_music;
    logic                   busy;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    logic                   done;
    logic                   aborted;

    modport master (
        output req_valid, req_sel,
        input  select_music, busy, grant_valid, grant_id, done, aborted
    );

    modport slave (
        input  req_valid, req_sel,
        output select_music, busy, grant_valid, grant_id, done, aborted
    );
endinterface

// File: rtl/music_req_arbiter.sv
// Strict-priority arbiter in front of the MUSIC player: latches track requests per requester,
// plays the winner for a fixed window and forces a silence gap between tracks.
module music_req_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned PLAY_UNITS = 5,
    parameter int unsigned GAP_CYCLES = 16
) (
    input logic                s_clk,
    input logic                s_rst,
    music_req_arbiter_if.slave bus
);
    localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned UNIT_W = (PLAY_UNITS > 1) ? $clog2(PLAY_UNITS) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(PLAY_UNITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e            state_q;
    logic [N_REQ-1:0]  slot_valid_q;
    logic [SEL_W-1:0]  slot_code_q [N_REQ];
    logic [TICK_W-1:0] tick_q;
    logic [UNIT_W-1:0] unit_q;
    logic [GAP_W-1:0]  gap_q;
    logic [SEL_W-1:0]  select_q;
    logic [ID_W-1:0]   grant_id_q;
    logic              busy_q;
    logic              grant_valid_q;
    logic              done_q;
    logic              aborted_q;

    logic [SEL_W-1:0]  req_code [N_REQ];
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              preempt;
    logic              owner_stop;
    logic              play_last;
    logic              gap_last;
    logic              do_grant;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        preempt   = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_code[i] = bus.req_sel[i*SEL_W +: SEL_W];
        end
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (slot_valid_q[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
        // Only strictly higher-priority requesters may cut the current track short.
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (slot_valid_q[i] && (ID_W'(i) < grant_id_q)) begin
                preempt = 1'b1;
            end
        end
        owner_stop = bus.req_valid[grant_id_q] && (req_code[grant_id_q] == '0);
        play_last  = (tick_q == TICK_LAST) && (unit_q == UNIT_LAST);
        gap_last   = (gap_q == GAP_LAST);
        do_grant   = win_found && ((state_q == StIdle) || ((state_q == StGap) && gap_last));
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q       <= StIdle;
            slot_valid_q  <= '0;
            tick_q        <= '0;
            unit_q        <= '0;
            gap_q         <= '0;
            select_q      <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            grant_valid_q <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                slot_code_q[i] <= '0;
            end
        end else begin
            grant_valid_q <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            if (do_grant) begin
                state_q              <= StPlay;
                busy_q               <= 1'b1;
                select_q             <= slot_code_q[win_id];
                grant_id_q           <= win_id;
                grant_valid_q        <= 1'b1;
                tick_q               <= '0;
                unit_q               <= '0;
                slot_valid_q[win_id] <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        tick_q <= '0;
                        unit_q <= '0;
                        gap_q  <= '0;
                    end
                    StPlay: begin
                        // A normal completion outranks preemption and stop in the same cycle.
                        if (play_last) begin
                            state_q  <= StGap;
                            select_q <= '0;
                            done_q   <= 1'b1;
                            gap_q    <= '0;
                        end else if (preempt || owner_stop) begin
                            state_q   <= StGap;
                            select_q  <= '0;
                            aborted_q <= 1'b1;
                            gap_q     <= '0;
                        end else if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            unit_q <= unit_q + UNIT_W'(1);
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                    StGap: begin
                        if (gap_last) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            gap_q   <= '0;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
            // Strobes are applied last so a fresh request survives the grant-time clear.
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (bus.req_valid[i]) begin
                    slot_valid_q[i] <= (req_code[i] != '0);
                    if (req_code[i] != '0) begin
                        slot_code_q[i] <= req_code[i];
                    end
                end
            end
        end
    end

    assign bus.select_music = select_q;
    assign bus.busy         = busy_q;
    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
endmodule

// File: tb/tb_music_req_arbiter.sv
// Bench for music_req_arbiter: directed test-plan scenarios plus random traffic, checked every
// cycle against a countdown-based behavioural model.
module tb_music_req_arbiter;
    localparam int unsigned N_REQ      = 4;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned PLAY_UNITS = 3;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int          PLAY_LEN   = int'(PLAY_UNITS * TICK_DIV);

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;

    music_req_arbiter_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) bus ();

    music_req_arbiter #(
        .N_REQ     (N_REQ),
        .SEL_W     (SEL_W),
        .TICK_DIV  (TICK_DIV),
        .PLAY_UNITS(PLAY_UNITS),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .s_clk(s_clk),
        .s_rst(s_rst),
        .bus  (bus)
    );

    always #5 s_clk = ~s_clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: 0 = idle, 1 = playing, 2 = gap; remaining-cycle countdowns instead of tick/unit.
    int         m_state;
    bit         m_pv [N_REQ];
    logic [3:0] m_pc [N_REQ];
    int         m_play_left;
    int         m_gap_left;
    int         m_sel;
    int         m_gid;
    bit         m_busy, m_gv, m_done, m_ab;

    int n_gv, n_done, n_ab, last_gid, first_gid;
    int cnt_sel [16];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_gv = 0; n_done = 0; n_ab = 0; last_gid = -1; first_gid = -1;
        for (int k = 0; k < 16; k++) cnt_sel[k] = 0;
    endtask

    task automatic model_step();
        int   win;
        bit   grant, pre, stop_own;
        logic [3:0] code;
        m_gv = 0; m_done = 0; m_ab = 0;
        if (s_rst) begin
            m_state = 0; m_play_left = 0; m_gap_left = 0;
            m_sel = 0; m_gid = 0; m_busy = 0;
            for (int i = 0; i < int'(N_REQ); i++) begin m_pv[i] = 0; m_pc[i] = 0; end
            return;
        end
        win = -1;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) if (m_pv[i]) win = i;
        grant = (win >= 0) && (m_state == 0 || (m_state == 2 && m_gap_left == 1));
        pre = 0;
        for (int i = 0; i < m_gid; i++) if (m_pv[i]) pre = 1;
        code = bus.req_sel[m_gid*SEL_W +: SEL_W];
        stop_own = bus.req_valid[m_gid] && (code == 4'd0);
        if (grant) begin
            m_state = 1; m_busy = 1; m_gv = 1;
            m_sel = int'(m_pc[win]); m_gid = win; m_pv[win] = 0;
            m_play_left = PLAY_LEN;
        end else if (m_state == 1) begin
            if (m_play_left == 1) begin
                m_state = 2; m_sel = 0; m_done = 1; m_gap_left = int'(GAP_CYCLES);
            end else if (pre || stop_own) begin
                m_state = 2; m_sel = 0; m_ab = 1; m_gap_left = int'(GAP_CYCLES);
            end else begin
                m_play_left--;
            end
        end else if (m_state == 2) begin
            if (m_gap_left == 1) begin m_state = 0; m_busy = 0; end
            else m_gap_left--;
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (bus.req_valid[i]) begin
                code = bus.req_sel[i*SEL_W +: SEL_W];
                m_pv[i] = (code != 4'd0);
                if (code != 4'd0) m_pc[i] = code;
            end
        end
    endtask

    // Apply current inputs across one clock edge and compare every output with the model.
    task automatic step();
        model_step();
        @(posedge s_clk);
        #1;
        chk("select_music", int'(bus.select_music), m_sel);
        chk("busy", int'(bus.busy), int'(m_busy));
        chk("grant_valid", int'(bus.grant_valid), int'(m_gv));
        chk("grant_id", int'(bus.grant_id), m_gid);
        chk("done", int'(bus.done), int'(m_done));
        chk("aborted", int'(bus.aborted), int'(m_ab));
        if (bus.grant_valid === 1'b1) begin
            n_gv++;
            last_gid = int'(bus.grant_id);
            if (first_gid < 0) first_gid = int'(bus.grant_id);
        end
        if (bus.done === 1'b1) n_done++;
        if (bus.aborted === 1'b1) n_ab++;
        if (!$isunknown(bus.select_music)) cnt_sel[bus.select_music]++;
        bus.req_valid = '0;
        bus.req_sel   = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic strobe(input int id, input int code);
        bus.req_valid[id] = 1'b1;
        bus.req_sel[id*SEL_W +: SEL_W] = SEL_W'(code);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_sel   = '0;
        clear_counts();
        s_rst = 1'b1;
        run(3);
        chk("reset_select", int'(bus.select_music), 0);
        chk("reset_busy", int'(bus.busy), 0);
        s_rst = 1'b0;
        run(7);

        // 1: single request, latency and window length
        clear_counts();
        strobe(0, 5);
        step();
        chk("s1_latency_edge1", int'(bus.select_music), 0);
        step();
        chk("s1_select_at_grant", int'(bus.select_music), 5);
        chk("s1_grant_pulse", int'(bus.grant_valid), 1);
        run(16);
        chk("s1_play_cycles", cnt_sel[5], 12);
        chk("s1_done_count", n_done, 1);
        chk("s1_idle_busy", int'(bus.busy), 0);

        // 2: preemption by a higher-priority requester
        strobe(2, 7);
        step();
        step();
        run(5);
        strobe(1, 3);
        step();
        clear_counts();
        run(20);
        chk("s2_aborts", n_ab, 1);
        chk("s2_no_replay", cnt_sel[7], 0);
        chk("s2_new_track", cnt_sel[3], 12);
        chk("s2_grant_id", last_gid, 1);

        // 3: lower-priority request waits for completion
        strobe(1, 3);
        step();
        step();
        run(4);
        strobe(3, 9);
        step();
        clear_counts();
        run(30);
        chk("s3_aborts", n_ab, 0);
        chk("s3_dones", n_done, 2);
        chk("s3_grant_id", last_gid, 3);
        chk("s3_track9", cnt_sel[9], 12);

        // 4: simultaneous requests from idle
        clear_counts();
        strobe(0, 4);
        strobe(2, 6);
        step();
        run(40);
        chk("s4_grants", n_gv, 2);
        chk("s4_dones", n_done, 2);
        chk("s4_first_id", first_gid, 0);
        chk("s4_track4", cnt_sel[4], 12);
        chk("s4_track6", cnt_sel[6], 12);

        // 5: owner stop, then a stop from a non-owner with an empty slot
        strobe(0, 8);
        step();
        step();
        run(3);
        strobe(0, 0);
        step();
        chk("s5_abort_pulse", int'(bus.aborted), 1);
        chk("s5_silenced", int'(bus.select_music), 0);
        run(4);
        clear_counts();
        strobe(2, 0);
        step();
        run(3);
        chk("s5_no_grant", n_gv, 0);
        chk("s5_busy", int'(bus.busy), 0);

        // 6: reset during play with requests pending
        strobe(0, 5);
        step();
        step();
        strobe(1, 2);
        strobe(3, 7);
        step();
        s_rst = 1'b1;
        step();
        chk("s6_reset_select", int'(bus.select_music), 0);
        chk("s6_reset_busy", int'(bus.busy), 0);
        s_rst = 1'b0;
        clear_counts();
        run(10);
        chk("s6_no_grant", n_gv, 0);
        chk("s6_idle", int'(bus.busy), 0);

        // Random traffic with occasional stops and resets
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    strobe(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)));
                end
            end
            s_rst = ($urandom_range(0, 499) == 0);
            step();
        end
        s_rst = 1'b0;
        run(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
